// File: rtl/aor_key_loader_checker_if.sv
// Key-provisioning handshake plus locked-adder operand/result bus and status.
// The slave modport is the loader/checker side, and the master modport is the bench/adder side.
interface aor_key_loader_checker_if #(
  parameter int KEY_W  = 32,
  parameter int DATA_W = 16,
  parameter int CNT_W  = 8
);
  logic              key_valid_i;
  logic              key_bit_i;
  logic              key_ready_o;
  logic [KEY_W-1:0]  key_o;
  logic [DATA_W-1:0] add1_o;
  logic [DATA_W-1:0] add2_o;
  logic [DATA_W:0]   result_i;
  logic              busy_o;
  logic              done_o;
  logic              unlock_ok_o;
  logic [CNT_W-1:0]  mismatch_cnt_o;

  modport slave (
    input  key_valid_i, key_bit_i, result_i,
    output key_ready_o, key_o, add1_o, add2_o, busy_o, done_o, unlock_ok_o, mismatch_cnt_o
  );

  modport master (
    output key_valid_i, key_bit_i, result_i,
    input  key_ready_o, key_o, add1_o, add2_o, busy_o, done_o, unlock_ok_o, mismatch_cnt_o
  );
endinterface

// File: rtl/aor_key_loader_checker.sv
// Serial key loader with an atomic commit to the AOR-locked adder key bus.
// After each commit, it self-tests the adder with LFSR operands and reports mismatches.
module aor_key_loader_checker #(
  parameter int          KEY_W     = 32,
  parameter int          DATA_W    = 16,
  parameter int          NUM_VEC   = 64,
  parameter logic [31:0] LFSR_SEED = 32'hACE1_1234,
  parameter int          CNT_W     = 8
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  aor_key_loader_checker_if.slave    bus
);

  localparam int          CW       = (KEY_W > 1) ? $clog2(KEY_W) : 1;
  localparam int          IW       = (NUM_VEC > 1) ? $clog2(NUM_VEC) : 1;
  localparam logic [31:0] POLY     = 32'h8020_0003;
  localparam logic [CW-1:0]    LAST_BIT = CW'(KEY_W - 1);
  localparam logic [IW-1:0]    LAST_VEC = IW'(NUM_VEC - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_SHIFT = 3'd1;
  localparam logic [2:0] S_DRIVE = 3'd2;
  localparam logic [2:0] S_CHECK = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  logic [2:0]        state_q,   state_d;
  logic [CW-1:0]     cnt_q,     cnt_d;
  logic [KEY_W-1:0]  shadow_q,  shadow_d;
  logic [KEY_W-1:0]  key_q,     key_d;
  logic [31:0]       lfsr_q,    lfsr_d;
  logic [DATA_W-1:0] add1_q,    add1_d;
  logic [DATA_W-1:0] add2_q,    add2_d;
  logic [IW-1:0]     idx_q,     idx_d;
  logic [CNT_W-1:0]  run_cnt_q, run_cnt_d;
  logic [CNT_W-1:0]  mm_q,      mm_d;
  logic              unlock_q,  unlock_d;
  logic              done_q,    done_d;

  logic              key_ready;
  logic              handshake;
  logic [DATA_W:0]   true_sum;
  logic              mismatch;
  logic [31:0]       lfsr_step;

  assign key_ready = (state_q == S_IDLE) || (state_q == S_SHIFT);
  assign handshake = bus.key_valid_i && key_ready;
  assign true_sum  = {1'b0, add1_q} + {1'b0, add2_q};
  assign mismatch  = (bus.result_i != true_sum);
  // Galois step: the shifted-out bit folds the taps back in.
  assign lfsr_step = {1'b0, lfsr_q[31:1]} ^ (lfsr_q[0] ? POLY : 32'h0);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    shadow_d  = shadow_q;
    key_d     = key_q;
    lfsr_d    = lfsr_q;
    add1_d    = add1_q;
    add2_d    = add2_q;
    idx_d     = idx_q;
    run_cnt_d = run_cnt_q;
    mm_d      = mm_q;
    unlock_d  = unlock_q;
    done_d    = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (handshake) begin
          shadow_d    = '0;
          shadow_d[0] = bus.key_bit_i;
          cnt_d       = CW'(1);
          state_d     = S_SHIFT;
        end
      end

      S_SHIFT: begin
        if (handshake) begin
          shadow_d[cnt_q] = bus.key_bit_i;
          if (cnt_q == LAST_BIT) begin
            // The whole key lands on key_o in one edge; the adder never sees a partial key.
            key_d     = shadow_d;
            lfsr_d    = LFSR_SEED;
            idx_d     = '0;
            run_cnt_d = '0;
            cnt_d     = '0;
            state_d   = S_DRIVE;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end

      S_DRIVE: begin
        add1_d  = DATA_W'(lfsr_q[15:0]);
        add2_d  = DATA_W'(lfsr_q[31:16]);
        state_d = S_CHECK;
      end

      S_CHECK: begin
        if (mismatch && (run_cnt_q != CNT_MAX))
          run_cnt_d = run_cnt_q + CNT_W'(1);
        lfsr_d = lfsr_step;
        if (idx_q == LAST_VEC) begin
          state_d = S_DONE;
        end else begin
          idx_d   = idx_q + IW'(1);
          state_d = S_DRIVE;
        end
      end

      S_DONE: begin
        // The status outputs and the done pulse appear together on the edge leaving DONE.
        mm_d     = run_cnt_q;
        unlock_d = (run_cnt_q == '0);
        done_d   = 1'b1;
        state_d  = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      shadow_q  <= '0;
      key_q     <= '0;
      lfsr_q    <= LFSR_SEED;
      add1_q    <= '0;
      add2_q    <= '0;
      idx_q     <= '0;
      run_cnt_q <= '0;
      mm_q      <= '0;
      unlock_q  <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      shadow_q  <= shadow_d;
      key_q     <= key_d;
      lfsr_q    <= lfsr_d;
      add1_q    <= add1_d;
      add2_q    <= add2_d;
      idx_q     <= idx_d;
      run_cnt_q <= run_cnt_d;
      mm_q      <= mm_d;
      unlock_q  <= unlock_d;
      done_q    <= done_d;
    end
  end

  assign bus.key_ready_o    = key_ready;
  assign bus.key_o          = key_q;
  assign bus.add1_o         = add1_q;
  assign bus.add2_o         = add2_q;
  assign bus.busy_o         = (state_q == S_SHIFT) || (state_q == S_DRIVE) || (state_q == S_CHECK);
  assign bus.done_o         = done_q;
  assign bus.unlock_ok_o    = unlock_q;
  assign bus.mismatch_cnt_o = mm_q;

endmodule

// File: tb/tb_aor_key_loader_checker.sv
// Randomized bench for the key loader/checker, with a behavioural locked-adder and LFSR model.
module tb_aor_key_loader_checker;
  localparam int          KEY_W    = 32;
  localparam int          DATA_W   = 16;
  localparam int          NUM_VEC  = 64;
  localparam int          CNT_W    = 8;
  localparam logic [31:0] SEED     = 32'hACE1_1234;
  localparam logic [31:0] POLY     = 32'h8020_0003;
  localparam logic [31:0] GOOD_KEY = 32'h2141_831B;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   errors = 0;
  int   checks = 0;

  logic [31:0] cur_key = '0;
  int          prev_mm = 0;
  bit          prev_ok = 1'b0;

  aor_key_loader_checker_if #(.KEY_W(KEY_W), .DATA_W(DATA_W), .CNT_W(CNT_W)) bus ();

  aor_key_loader_checker #(
    .KEY_W(KEY_W), .DATA_W(DATA_W), .NUM_VEC(NUM_VEC), .LFSR_SEED(SEED), .CNT_W(CNT_W)
  ) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  // Stand-in locked adder: exact sum only under the correct key; wrong key bits corrupt sum bits.
  function automatic logic [16:0] locked_add(input logic [15:0] a, input logic [15:0] b,
                                             input logic [31:0] key);
    logic [31:0] d;
    d = key ^ GOOD_KEY;
    return ({1'b0, a} + {1'b0, b}) ^ {1'b0, (d[15:0] & a) ^ (d[31:16] & b)};
  endfunction

  assign bus.result_i = locked_add(bus.add1_o, bus.add2_o, bus.key_o);

  // Expected self-test outcome: walk the operand sequence and count wrong sums.
  task automatic model(input logic [31:0] key, output int mm, output logic [15:0] la,
                       output logic [15:0] lb);
    logic [31:0] l;
    l  = SEED;
    mm = 0;
    la = '0;
    lb = '0;
    for (int v = 0; v < NUM_VEC; v++) begin
      la = l[15:0];
      lb = l[31:16];
      if (locked_add(la, lb, key) != (17'(la) + 17'(lb))) mm++;
      l = (l >> 1) ^ (l[0] ? POLY : 32'h0);
    end
    if (mm > (1 << CNT_W) - 1) mm = (1 << CNT_W) - 1;
  endtask

  // Sends nbits of key LSB-first; gap 0=contiguous, 1=alternate idle cycles, 2=random idles.
  task automatic send_key(input logic [31:0] key, input int gap, input int nbits);
    @(negedge clk);
    for (int i = 0; i < nbits; i++) begin
      checks++;
      if (bus.key_o !== cur_key) begin
        errors++;
        $display("FAIL key_no_partial bit%0d: got %h expected %h", i, bus.key_o, cur_key);
      end
      if (i > 0) begin
        checks++;
        if (bus.busy_o !== 1'b1 || bus.key_ready_o !== 1'b1) begin
          errors++;
          $display("FAIL shift_flags bit%0d: busy=%b ready=%b expected 1 1", i, bus.busy_o,
                   bus.key_ready_o);
        end
      end
      bus.key_valid_i = 1'b1;
      bus.key_bit_i   = key[i];
      @(negedge clk);
      bus.key_valid_i = 1'b0;
      if (i != KEY_W - 1 && (gap == 1 || (gap == 2 && $urandom_range(0, 2) == 0))) begin
        bus.key_bit_i = 1'($urandom);
        @(negedge clk);
      end
    end
    if (nbits == KEY_W) begin
      checks++;
      if (bus.key_o !== key) begin
        errors++;
        $display("FAIL key_commit: got %h expected %h", bus.key_o, key);
      end
      cur_key = key;
    end
  endtask

  // Follows one self-test from the last-bit edge; optionally pokes key_valid_i mid-test.
  task automatic wait_done(input logic [31:0] key, input bit inject);
    int          emm, n;
    logic [15:0] la, lb;
    model(key, emm, la, lb);
    n = 0;
    while (bus.done_o !== 1'b1 && n < 400) begin
      @(negedge clk);
      n++;
      if (n == 1) begin
        checks++;
        if (bus.add1_o !== SEED[15:0] || bus.add2_o !== SEED[31:16]) begin
          errors++;
          $display("FAIL first_operands: got %h %h expected %h %h", bus.add1_o, bus.add2_o,
                   SEED[15:0], SEED[31:16]);
        end
      end
      if (n == 64) begin
        checks++;
        if (bus.mismatch_cnt_o !== CNT_W'(prev_mm) || bus.unlock_ok_o !== prev_ok ||
            bus.busy_o !== 1'b1) begin
          errors++;
          $display("FAIL hold_midtest: got mm=%0d ok=%b busy=%b expected %0d %b 1",
                   bus.mismatch_cnt_o, bus.unlock_ok_o, bus.busy_o, prev_mm, prev_ok);
        end
      end
      if (inject && n >= 2 && n <= 120) begin
        checks++;
        if (bus.key_ready_o !== 1'b0) begin
          errors++;
          $display("FAIL ready_in_test n=%0d: got %b expected 0", n, bus.key_ready_o);
        end
        bus.key_valid_i = 1'($urandom);
        bus.key_bit_i   = 1'($urandom);
      end else begin
        bus.key_valid_i = 1'b0;
      end
    end
    bus.key_valid_i = 1'b0;
    checks++;
    if (n != 2 * NUM_VEC + 1) begin
      errors++;
      $display("FAIL done_latency: got %0d expected %0d", n, 2 * NUM_VEC + 1);
    end
    checks++;
    if (bus.mismatch_cnt_o !== CNT_W'(emm) || bus.unlock_ok_o !== (emm == 0)) begin
      errors++;
      $display("FAIL result: got mm=%0d ok=%b expected mm=%0d ok=%b", bus.mismatch_cnt_o,
               bus.unlock_ok_o, emm, emm == 0);
    end
    checks++;
    if (bus.key_o !== key || bus.add1_o !== la || bus.add2_o !== lb) begin
      errors++;
      $display("FAIL final_state: got key=%h a=%h b=%h expected %h %h %h", bus.key_o,
               bus.add1_o, bus.add2_o, key, la, lb);
    end
    @(negedge clk);
    checks++;
    if (bus.done_o !== 1'b0 || bus.busy_o !== 1'b0 || bus.key_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL after_done: got done=%b busy=%b ready=%b expected 0 0 1", bus.done_o,
               bus.busy_o, bus.key_ready_o);
    end
    prev_mm = emm;
    prev_ok = (emm == 0);
  endtask

  task automatic test_reset();
    bus.key_valid_i = 1'b0;
    bus.key_bit_i   = 1'b0;
    #12;
    rst_n = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      checks++;
      if (bus.key_o !== '0 || bus.key_ready_o !== 1'b1 || bus.busy_o !== 1'b0 ||
          bus.done_o !== 1'b0 || bus.unlock_ok_o !== 1'b0 || bus.mismatch_cnt_o !== '0 ||
          bus.add1_o !== '0 || bus.add2_o !== '0) begin
        errors++;
        $display("FAIL reset_idle c%0d: got key=%h rdy=%b busy=%b done=%b ok=%b mm=%0d", c,
                 bus.key_o, bus.key_ready_o, bus.busy_o, bus.done_o, bus.unlock_ok_o,
                 bus.mismatch_cnt_o);
      end
    end
  endtask

  task automatic test_correct_key();
    send_key(GOOD_KEY, 0, KEY_W);
    wait_done(GOOD_KEY, 1'b0);
    checks++;
    if (bus.unlock_ok_o !== 1'b1 || bus.mismatch_cnt_o !== '0) begin
      errors++;
      $display("FAIL good_key_unlock: got ok=%b mm=%0d expected 1 0", bus.unlock_ok_o,
               bus.mismatch_cnt_o);
    end
  endtask

  task automatic test_zero_key();
    send_key(32'h0, 0, KEY_W);
    wait_done(32'h0, 1'b0);
    checks++;
    if (bus.unlock_ok_o !== 1'b0 || bus.mismatch_cnt_o == '0) begin
      errors++;
      $display("FAIL zero_key_locked: got ok=%b mm=%0d expected 0 and nonzero",
               bus.unlock_ok_o, bus.mismatch_cnt_o);
    end
  endtask

  task automatic test_gapped_key();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n   = 1'b1;
    cur_key = '0;
    prev_mm = 0;
    prev_ok = 1'b0;
    send_key(GOOD_KEY, 1, KEY_W);
    wait_done(GOOD_KEY, 1'b0);
  endtask

  task automatic test_ignore_during_test();
    logic [31:0] k;
    k = $urandom;
    send_key(k, 2, KEY_W);
    wait_done(k, 1'b1);
  endtask

  task automatic test_async_reset(input bit mid_test);
    logic [31:0] k;
    k = $urandom;
    if (mid_test) begin
      send_key(k, 0, KEY_W);
      for (int c = 0; c < 21; c++) @(negedge clk);
    end else begin
      send_key(k, 0, 17);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.key_o !== '0 || bus.key_ready_o !== 1'b1 || bus.busy_o !== 1'b0 ||
        bus.done_o !== 1'b0 || bus.unlock_ok_o !== 1'b0 || bus.mismatch_cnt_o !== '0 ||
        bus.add1_o !== '0 || bus.add2_o !== '0) begin
      errors++;
      $display("FAIL async_reset mid_test=%0d: got key=%h rdy=%b busy=%b ok=%b mm=%0d a=%h",
               mid_test, bus.key_o, bus.key_ready_o, bus.busy_o, bus.unlock_ok_o,
               bus.mismatch_cnt_o, bus.add1_o);
    end
    @(negedge clk);
    rst_n   = 1'b1;
    cur_key = '0;
    prev_mm = 0;
    prev_ok = 1'b0;
    k = mid_test ? 32'($urandom) : GOOD_KEY;
    send_key(k, 0, KEY_W);
    wait_done(k, 1'b0);
  endtask

  task automatic test_back_to_back();
    logic [31:0] k;
    for (int r = 0; r < 4; r++) begin
      k = (r == 3) ? (GOOD_KEY ^ (32'h1 << $urandom_range(0, 31))) : 32'($urandom);
      send_key(k, 2, KEY_W);
      wait_done(k, 1'b0);
    end
  endtask

  initial begin
    test_reset();
    test_correct_key();
    test_zero_key();
    test_gapped_key();
    test_async_reset(1'b0);
    test_ignore_during_test();
    test_async_reset(1'b1);
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
